// File: rtl/rgb_gray_stream.sv
// Packed RGB to OW-bit gray/binary converter: two-stage back-pressured stream
// pipeline with per-frame min/max statistics latched on the last pixel.
module rgb_gray_stream #(
  parameter int CW = 4,
  parameter int OW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [3*CW-1:0] x_data,
  input  logic            x_last,
  input  logic [1:0]      mode,
  input  logic [OW-1:0]   thresh,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [OW-1:0]   y_data,
  output logic            y_last,
  output logic [OW-1:0]   stats_min,
  output logic [OW-1:0]   stats_max,
  output logic            stats_valid
);

  localparam logic [1:0] MODE_AVG    = 2'd0;
  localparam logic [1:0] MODE_LUMA   = 2'd1;
  localparam logic [1:0] MODE_GREEN  = 2'd2;
  localparam logic [1:0] MODE_THRESH = 2'd3;

  localparam logic [OW+9:0] K_AVG = (OW+10)'(171);
  localparam logic [OW+9:0] K_R   = (OW+10)'(77);
  localparam logic [OW+9:0] K_G   = (OW+10)'(150);
  localparam logic [OW+9:0] K_B   = (OW+10)'(29);

  // Repeat the channel MSB-first until OW bits are filled.
  function automatic logic [OW-1:0] expand(input logic [CW-1:0] c);
    logic [OW-1:0] e;
    e = '0;
    for (int i = 0; i < OW; i++) begin
      e[OW-1-i] = c[CW-1-(i%CW)];
    end
    return e;
  endfunction

  logic          v1, v2;
  logic          en1, en2;
  logic [OW-1:0] r1, g1, b1, thresh1;
  logic [1:0]    mode1;
  logic          last1;
  logic [OW-1:0] y_q;
  logic          last2;

  // Handshake: a beat transfers on any edge where valid & ready are both high.
  // A stage may load when it is empty or its content moves on this cycle; the
  // ready chain is purely combinational so no bubbles appear at full rate.
  assign en2     = ~v2 | y_ready;
  assign en1     = ~v1 | en2;
  assign x_ready = en1;
  assign y_valid = v2;
  assign y_data  = y_q;
  assign y_last  = last2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      r1      <= '0;
      g1      <= '0;
      b1      <= '0;
      thresh1 <= '0;
      mode1   <= MODE_AVG;
      last1   <= 1'b0;
    end else if (en1) begin
      v1 <= x_valid;
      if (x_valid) begin
        r1      <= expand(x_data[3*CW-1:2*CW]);
        g1      <= expand(x_data[2*CW-1:CW]);
        b1      <= expand(x_data[CW-1:0]);
        thresh1 <= thresh;
        mode1   <= mode;
        last1   <= x_last;
      end
    end
  end

  logic [OW+1:0] sum;
  logic [OW+9:0] avg_p, luma_p;
  logic [OW-1:0] avg, luma, result;

  always_comb begin
    sum    = {2'b00, r1} + {2'b00, g1} + {2'b00, b1};
    avg_p  = {8'd0, sum} * K_AVG;
    luma_p = K_R * {10'd0, r1} + K_G * {10'd0, g1} + K_B * {10'd0, b1};
    avg    = OW'(avg_p >> 9);
    luma   = OW'(luma_p >> 8);
    result = '0;
    case (mode1)
      MODE_AVG:    result = avg;
      MODE_LUMA:   result = luma;
      MODE_GREEN:  result = g1;
      MODE_THRESH: result = (luma >= thresh1) ? {OW{1'b1}} : '0;
      default:     result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      y_q   <= '0;
      last2 <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        y_q   <= result;
        last2 <= last1;
      end
    end
  end

  logic          y_hs;
  logic [OW-1:0] run_min, run_max, next_min, next_max;

  assign y_hs     = v2 & y_ready;
  assign next_min = (y_q < run_min) ? y_q : run_min;
  assign next_max = (y_q > run_max) ? y_q : run_max;

  // The last beat's value is folded in before the frame result is published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min     <= {OW{1'b1}};
      run_max     <= '0;
      stats_min   <= '0;
      stats_max   <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (y_hs) begin
        if (last2) begin
          stats_min   <= next_min;
          stats_max   <= next_max;
          stats_valid <= 1'b1;
          run_min     <= {OW{1'b1}};
          run_max     <= '0;
        end else begin
          run_min <= next_min;
          run_max <= next_max;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_gray_stream.sv
// Directed bench for rgb_gray_stream: reset, modes, threshold, back-pressure,
// frame statistics and a CW=5 instance.
module tb_rgb_gray_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid;
  logic        x_ready;
  logic [11:0] x_data;
  logic        x_last;
  logic [1:0]  mode;
  logic [7:0]  thresh;
  logic        y_valid;
  logic        y_ready;
  logic [7:0]  y_data;
  logic        y_last;
  logic [7:0]  stats_min;
  logic [7:0]  stats_max;
  logic        stats_valid;

  logic        x5_valid;
  logic        x5_ready;
  logic [14:0] x5_data;
  logic        x5_last;
  logic        y5_valid;
  logic        y5_ready;
  logic [7:0]  y5_data;
  logic        y5_last;
  logic [7:0]  stats5_min;
  logic [7:0]  stats5_max;
  logic        stats5_valid;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  rgb_gray_stream #(.CW(4), .OW(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .mode(mode), .thresh(thresh),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last),
    .stats_min(stats_min), .stats_max(stats_max), .stats_valid(stats_valid)
  );

  rgb_gray_stream #(.CW(5), .OW(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x5_valid), .x_ready(x5_ready), .x_data(x5_data), .x_last(x5_last),
    .mode(mode), .thresh(thresh),
    .y_valid(y5_valid), .y_ready(y5_ready), .y_data(y5_data), .y_last(y5_last),
    .stats_min(stats5_min), .stats_max(stats5_max), .stats_valid(stats5_valid)
  );

  task automatic idle(input int n);
    x_valid = 1'b0;
    x_last  = 1'b0;
    y_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    x_valid = 1'b0;
    rst_n   = 1'b0;
    #3;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    x_valid = 1'b1;
    x_data  = 12'hFFF;
    mode    = 2'd1;
    y_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (x_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold_x_ready: got %b want 1", x_ready);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (y_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_prefill_y_valid: got %b want 1", y_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({y_valid, y_data, y_last, stats_min, stats_max, stats_valid, x_ready} !== {1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_values: got yv=%b yd=%0d yl=%b smin=%0d smax=%0d sv=%b xr=%b want 0 0 0 0 0 0 1",
               y_valid, y_data, y_last, stats_min, stats_max, stats_valid, x_ready);
    end
    x_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (y_valid !== 1'b0 || x_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset_release_%0d: got yv=%b xr=%b want yv=0 xr=1", i, y_valid, x_ready);
      end
    end
  endtask

  task automatic test_modes();
    logic [11:0] d_t[5] = '{12'hF00, 12'hF00, 12'h0F0, 12'hFFF, 12'h0A0};
    logic [1:0]  m_t[5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [7:0]  e_t[5] = '{8'd85, 8'd76, 8'd149, 8'd255, 8'd170};
    y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x_valid = 1'b1;
      x_data  = d_t[i];
      mode    = m_t[i];
      @(posedge clk);
      #1;
      x_valid = 1'b0;
      checks++;
      if (y_valid !== 1'b0) begin
        fails++;
        $display("FAIL mode_early_%0d: y_valid got %b want 0 one cycle after accept", i, y_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (y_valid !== 1'b1 || y_data !== e_t[i]) begin
        fails++;
        $display("FAIL mode_%0d_data_%03h: got yv=%b yd=%0d want yv=1 yd=%0d", m_t[i], d_t[i], y_valid, y_data, e_t[i]);
      end
    end
  endtask

  task automatic test_threshold();
    logic [11:0] d_t[4] = '{12'h0F0, 12'h0F0, 12'hF00, 12'hF00};
    logic [7:0]  t_t[4] = '{8'd128, 8'd200, 8'd128, 8'd50};
    logic [7:0]  e_t[4] = '{8'd255, 8'd0, 8'd0, 8'd255};
    y_ready = 1'b1;
    mode    = 2'd3;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        x_valid = 1'b1;
        x_data  = d_t[i];
        thresh  = t_t[i];
      end else begin
        x_valid = 1'b0;
        thresh  = 8'd0;
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        checks++;
        if (y_valid !== 1'b1 || y_data !== e_t[i-1]) begin
          fails++;
          $display("FAIL thresh_beat_%0d: got yv=%b yd=%0d want yv=1 yd=%0d", i-1, y_valid, y_data, e_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic m1, m2, yr, en1, en2, acc;
    int sent, got, cyc;
    m1 = 1'b0; m2 = 1'b0; sent = 0; got = 0; cyc = 0;
    exp_q.delete();
    mode = 2'd2;
    while (got < 10 && cyc < 80) begin
      yr      = pat[cyc % 4];
      y_ready = yr;
      x_valid = (sent < 10);
      x_data  = {4'(sent), 4'(sent + 3), 4'(15 - sent)};
      #1;
      en2 = !m2 || yr;
      en1 = !m1 || en2;
      checks++;
      if (x_ready !== en1 || y_valid !== m2) begin
        fails++;
        $display("FAIL bp_flags_cyc%0d: got xr=%b yv=%b want xr=%b yv=%b", cyc, x_ready, y_valid, en1, m2);
      end
      if (m2 && yr) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL bp_extra_beat: got yd=%0d want no beat", y_data);
        end else if (y_data !== exp_q[0]) begin
          fails++;
          $display("FAIL bp_data_%0d: got %0d want %0d", got, y_data, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      acc = x_valid && en1;
      if (acc) begin
        exp_q.push_back(8'(17 * (sent + 3)));
        sent++;
      end
      if (en2) m2 = m1;
      if (en1) m1 = acc;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (got !== 10 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got %0d beats (%0d pending) want 10 (0 pending)", got, exp_q.size());
    end
  endtask

  task automatic test_stats();
    logic [11:0] d_t[6] = '{12'h230, 12'h7F8, 12'h101, 12'h183, 12'h240, 12'h250};
    logic [7:0]  e_t[6] = '{8'd40, 8'd200, 8'd7, 8'd90, 8'd50, 8'd60};
    logic        l_t[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pulse_reset();
    y_ready = 1'b1;
    mode    = 2'd1;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        x_valid = 1'b1;
        x_data  = d_t[i];
        x_last  = l_t[i];
      end else begin
        x_valid = 1'b0;
        x_last  = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 1 && i <= 6) begin
        checks++;
        if (y_valid !== 1'b1 || y_data !== e_t[i-1] || y_last !== l_t[i-1]) begin
          fails++;
          $display("FAIL stats_beat_%0d: got yv=%b yd=%0d yl=%b want yv=1 yd=%0d yl=%b",
                   i-1, y_valid, y_data, y_last, e_t[i-1], l_t[i-1]);
        end
      end
      checks++;
      if (stats_valid !== (i == 5 || i == 7)) begin
        fails++;
        $display("FAIL stats_valid_cyc%0d: got %b want %b", i, stats_valid, (i == 5 || i == 7));
      end
      if (i == 5) begin
        checks++;
        if (stats_min !== 8'd7 || stats_max !== 8'd200) begin
          fails++;
          $display("FAIL stats_frame1: got min=%0d max=%0d want min=7 max=200", stats_min, stats_max);
        end
      end
      if (i == 7) begin
        checks++;
        if (stats_min !== 8'd50 || stats_max !== 8'd60) begin
          fails++;
          $display("FAIL stats_frame2: got min=%0d max=%0d want min=50 max=60", stats_min, stats_max);
        end
      end
    end
  endtask

  task automatic test_param();
    logic [14:0] d_t[2] = '{{5'd0, 5'b10110, 5'd0}, {5'd31, 5'd0, 5'd0}};
    logic [1:0]  m_t[2] = '{2'd2, 2'd1};
    logic [7:0]  e_t[2] = '{8'd181, 8'd76};
    for (int i = 0; i < 2; i++) begin
      x5_valid = 1'b1;
      x5_data  = d_t[i];
      mode     = m_t[i];
      @(posedge clk);
      #1;
      x5_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (y5_valid !== 1'b1 || y5_data !== e_t[i]) begin
        fails++;
        $display("FAIL cw5_case_%0d: got yv=%b yd=%0d want yv=1 yd=%0d", i, y5_valid, y5_data, e_t[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    x_valid  = 1'b0;
    x_data   = '0;
    x_last   = 1'b0;
    mode     = 2'd0;
    thresh   = 8'd128;
    y_ready  = 1'b0;
    x5_valid = 1'b0;
    x5_data  = '0;
    x5_last  = 1'b0;
    y5_ready = 1'b1;
    test_reset();
    idle(3);
    test_modes();
    idle(3);
    thresh = 8'd128;
    test_threshold();
    idle(3);
    test_backpressure();
    idle(3);
    test_stats();
    idle(3);
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
